// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter: transfer encodings,
// master indices and the captured address/control payload.
package ahbl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic              write;
    } ahb_ctrl_t;

    // SEQ is treated exactly like NONSEQ; BUSY and IDLE carry no transfer.
    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_arb_hold.sv
// Per-master hold register: keeps an accepted-but-not-issued address phase
// until the arbiter grants that master the slave bus.
module ahbl_arb_hold
    import ahbl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      live,
    input  logic      issued,
    input  ahb_ctrl_t ctrl_in,
    output logic      pend,
    output ahb_ctrl_t held
);

    // Issue wins over capture; a live transfer that is issued is never held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            held <= '0;
        end else if (issued) begin
            pend <= 1'b0;
        end else if (live) begin
            pend <= 1'b1;
            held <= ctrl_in;
        end
    end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of the address splitter; the losing
// master only ever sees wait states.
module ahbl_master_arbiter
    import ahbl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [1:0]        M0_HTRANS,
    input  logic [SIZE_W-1:0] M0_HSIZE,
    input  logic              M0_HWRITE,
    input  logic [DATA_W-1:0] M0_HWDATA,
    output logic              M0_HREADY,
    output logic [DATA_W-1:0] M0_HRDATA,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [1:0]        M1_HTRANS,
    input  logic [SIZE_W-1:0] M1_HSIZE,
    input  logic              M1_HWRITE,
    input  logic [DATA_W-1:0] M1_HWDATA,
    output logic              M1_HREADY,
    output logic [DATA_W-1:0] M1_HRDATA,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic [SIZE_W-1:0] S_HSIZE,
    output logic              S_HWRITE,
    output logic [DATA_W-1:0] S_HWDATA,
    input  logic              S_HREADY,
    input  logic [DATA_W-1:0] S_HRDATA
);

    logic [1:0] rdy, live, req, issued, pend;
    logic       gnt, gnt_q, last_q, dvalid_q, downer_q, s_req;
    ahb_ctrl_t  cur0, cur1, held0, held1, sel;

    assign cur0 = '{addr: M0_HADDR, size: M0_HSIZE, write: M0_HWRITE};
    assign cur1 = '{addr: M1_HADDR, size: M1_HSIZE, write: M1_HWRITE};

    // Master-side ready: data-phase owner follows the slave, a held master waits.
    always_comb begin
        rdy = 2'b11;
        if (HRESETn) begin
            if (dvalid_q && downer_q == M0) rdy[0] = S_HREADY;
            else if (pend[0])               rdy[0] = 1'b0;
            if (dvalid_q && downer_q == M1) rdy[1] = S_HREADY;
            else if (pend[1])               rdy[1] = 1'b0;
        end
    end

    assign M0_HREADY = rdy[0];
    assign M1_HREADY = rdy[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    assign live[0] = htrans_active(M0_HTRANS) & rdy[0] & ~pend[0];
    assign live[1] = htrans_active(M1_HTRANS) & rdy[1] & ~pend[1];
    assign req     = {2{HRESETn}} & (pend | live);

    // Grant only moves while the slave is ready; otherwise the bus stays frozen.
    always_comb begin
        gnt = gnt_q;
        if (S_HREADY) begin
            if (req[0] && req[1]) gnt = RR_EN ? ~last_q : M0;
            else if (req[0])      gnt = M0;
            else if (req[1])      gnt = M1;
        end
    end

    assign issued[0] = (gnt == M0) & req[0] & S_HREADY;
    assign issued[1] = (gnt == M1) & req[1] & S_HREADY;

    assign s_req    = (gnt == M1) ? req[1] : req[0];
    assign sel      = (gnt == M1) ? (pend[1] ? held1 : cur1) : (pend[0] ? held0 : cur0);
    assign S_HTRANS = s_req ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HADDR  = s_req ? sel.addr  : '0;
    assign S_HSIZE  = s_req ? sel.size  : '0;
    assign S_HWRITE = s_req ? sel.write : 1'b0;
    assign S_HWDATA = (dvalid_q && downer_q == M1) ? M1_HWDATA : M0_HWDATA;

    // Grant, round-robin history and data-phase ownership.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gnt_q    <= M0;
            last_q   <= M1;
            dvalid_q <= 1'b0;
            downer_q <= M0;
        end else begin
            gnt_q <= gnt;
            if (|issued) begin
                last_q   <= gnt;
                dvalid_q <= 1'b1;
                downer_q <= gnt;
            end else if (S_HREADY) begin
                dvalid_q <= 1'b0;
            end
        end
    end

    ahbl_arb_hold u_hold0 (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .live    (live[0]),
        .issued  (issued[0]),
        .ctrl_in (cur0),
        .pend    (pend[0]),
        .held    (held0)
    );

    ahbl_arb_hold u_hold1 (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .live    (live[1]),
        .issued  (issued[1]),
        .ctrl_in (cur1),
        .pend    (pend[1]),
        .held    (held1)
    );

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for the two-master arbiter: round-robin instance under test,
// plus a fixed-priority instance sharing the same master stimulus.
module tb_ahbl_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] M0_HADDR = '0, M1_HADDR = '0;
    logic [1:0]  M0_HTRANS = 2'b00, M1_HTRANS = 2'b00;
    logic [2:0]  M0_HSIZE = 3'd2, M1_HSIZE = 3'd2;
    logic        M0_HWRITE = 1'b0, M1_HWRITE = 1'b0;
    logic [31:0] M0_HWDATA = '0, M1_HWDATA = '0;
    logic        M0_HREADY, M1_HREADY;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] S_HADDR, S_HWDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic        S_HWRITE;
    logic        S_HREADY = 1'b1;
    logic [31:0] S_HRDATA;

    logic        fp_M0_HREADY, fp_M1_HREADY, fp_S_HWRITE;
    logic [31:0] fp_M0_HRDATA, fp_M1_HRDATA, fp_S_HADDR, fp_S_HWDATA;
    logic [1:0]  fp_S_HTRANS;
    logic [2:0]  fp_S_HSIZE;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          k0, k1;
    logic [31:0] dp_addr;

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.RR_EN(1'b1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA),
        .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA),
        .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
        .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA),
        .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
    );

    ahbl_master_arbiter #(.RR_EN(1'b0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
        .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA),
        .M0_HREADY(fp_M0_HREADY), .M0_HRDATA(fp_M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
        .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA),
        .M1_HREADY(fp_M1_HREADY), .M1_HRDATA(fp_M1_HRDATA),
        .S_HADDR(fp_S_HADDR), .S_HTRANS(fp_S_HTRANS), .S_HSIZE(fp_S_HSIZE),
        .S_HWRITE(fp_S_HWRITE), .S_HWDATA(fp_S_HWDATA),
        .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA)
    );

    // Slave stand-in: read data is a fixed scramble of the data-phase address.
    always_ff @(posedge HCLK) begin
        if (S_HREADY && S_HTRANS[1]) dp_addr <= S_HADDR;
    end
    assign S_HRDATA = dp_addr ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every accepted slave address phase must match the next scoreboard entry.
    task automatic monitor();
        exp_t e;
        if (S_HREADY && S_HTRANS == 2'b10) begin
            check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_addr", S_HADDR, e.addr);
                check("issue_write", 32'(S_HWRITE), 32'(e.write));
            end
        end
    endtask

    task automatic settle();
        #1;
        monitor();
    endtask

    task automatic nxt();
        @(negedge HCLK);
    endtask

    task automatic idle_masters();
        M0_HTRANS = 2'b00;
        M1_HTRANS = 2'b00;
        M0_HWRITE = 1'b0;
        M1_HWRITE = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_masters();
        settle();
        check("rst_m0_hready", 32'(M0_HREADY), 32'd1);
        check("rst_m1_hready", 32'(M1_HREADY), 32'd1);
        check("rst_s_htrans", 32'(S_HTRANS), 32'd0);
        nxt();
        settle();
        nxt();
        HRESETn = 1'b1;
        settle();
        check("post_rst_s_htrans", 32'(S_HTRANS), 32'd0);
        check("post_rst_s_haddr", S_HADDR, 32'd0);
        check("post_rst_s_hsize", 32'(S_HSIZE), 32'd0);
        check("post_rst_s_hwrite", 32'(S_HWRITE), 32'd0);
        check("post_rst_m0_hready", 32'(M0_HREADY), 32'd1);
        check("post_rst_m1_hready", 32'(M1_HREADY), 32'd1);
        nxt();
    endtask

    initial begin
        nxt();
        do_reset();

        // M0 alone: same-cycle issue, read data next cycle.
        M0_HTRANS = 2'b10; M0_HADDR = 32'h2000_0010; M0_HSIZE = 3'd2;
        exp_q.push_back('{addr: 32'h2000_0010, write: 1'b0});
        settle();
        check("t1_s_haddr", S_HADDR, 32'h2000_0010);
        check("t1_s_htrans", 32'(S_HTRANS), 32'h2);
        check("t1_s_hsize", 32'(S_HSIZE), 32'd2);
        nxt();
        idle_masters();
        settle();
        check("t1_m0_hready", 32'(M0_HREADY), 32'd1);
        check("t1_m0_hrdata", M0_HRDATA, 32'h2000_0010 ^ 32'hA5A5_0000);
        check("t1_m1_hready", 32'(M1_HREADY), 32'd1);
        nxt();
        settle();
        nxt();

        // Simultaneous requests right after reset: M0 first, M1 held one slot.
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0100;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h4000_0000;
        exp_q.push_back('{addr: 32'h0000_0100, write: 1'b0});
        exp_q.push_back('{addr: 32'h4000_0000, write: 1'b0});
        settle();
        check("t2_first_m0", S_HADDR, 32'h0000_0100);
        check("t2_m1_accepted", 32'(M1_HREADY), 32'd1);
        nxt();
        idle_masters();
        settle();
        check("t2_m1_wait", 32'(M1_HREADY), 32'd0);
        check("t2_m1_issue", S_HADDR, 32'h4000_0000);
        check("t2_m0_done", 32'(M0_HREADY), 32'd1);
        nxt();
        settle();
        check("t2_m1_done", 32'(M1_HREADY), 32'd1);
        check("t2_m1_hrdata", M1_HRDATA, 32'h4000_0000 ^ 32'hA5A5_0000);
        nxt();

        // Both masters streaming: round-robin alternates, fixed priority starves M1.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: 32'h1000_0000 + 32'(i * 4), write: 1'b0});
            exp_q.push_back('{addr: 32'h3000_0000 + 32'(i * 4), write: 1'b0});
        end
        exp_q.push_back('{addr: 32'h1000_0010, write: 1'b0});
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 8; c++) begin
            M0_HTRANS = 2'b10; M0_HADDR = 32'h1000_0000 + 32'(k0 * 4);
            M1_HTRANS = 2'b10; M1_HADDR = 32'h3000_0000 + 32'(k1 * 4);
            settle();
            if (c > 0) begin
                check("t3_fp_m1_starved", 32'(fp_M1_HREADY), 32'd0);
                check("t3_fp_s_haddr", fp_S_HADDR, 32'h1000_0000 + 32'(k0 * 4));
            end
            if (M0_HREADY) k0++;
            if (M1_HREADY) k1++;
            nxt();
        end
        idle_masters();
        settle();
        nxt();
        settle();
        nxt();

        // Slave stalls M0's data phase for 3 cycles while M1 arrives.
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0200;
        exp_q.push_back('{addr: 32'h0000_0200, write: 1'b0});
        exp_q.push_back('{addr: 32'h8000_0004, write: 1'b0});
        settle();
        nxt();
        idle_masters();
        S_HREADY = 1'b0;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h8000_0004;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("t4_m0_stall", 32'(M0_HREADY), 32'd0);
            check("t4_s_htrans_stable", 32'(S_HTRANS), 32'd0);
            check("t4_s_haddr_stable", S_HADDR, 32'd0);
            nxt();
            M1_HTRANS = 2'b00;
        end
        S_HREADY = 1'b1;
        settle();
        check("t4_m0_done", 32'(M0_HREADY), 32'd1);
        check("t4_m0_hrdata", M0_HRDATA, 32'h0000_0200 ^ 32'hA5A5_0000);
        check("t4_m1_issue", S_HADDR, 32'h8000_0004);
        check("t4_m1_htrans", 32'(S_HTRANS), 32'h2);
        nxt();
        settle();
        nxt();

        // M1 write: write data follows the data-phase owner, not M0.
        M1_HTRANS = 2'b10; M1_HADDR = 32'h2000_0020; M1_HWRITE = 1'b1;
        M0_HWDATA = 32'h1234_5678;
        exp_q.push_back('{addr: 32'h2000_0020, write: 1'b1});
        settle();
        nxt();
        idle_masters();
        M1_HWDATA = 32'hDEAD_BEEF;
        settle();
        check("t5_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);
        check("t5_m1_hready", 32'(M1_HREADY), 32'd1);
        nxt();
        settle();
        check("t5_idle_hwdata", S_HWDATA, 32'h1234_5678);
        nxt();

        // Reset with M1 held and M0 in flight: M1's address must never issue.
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0300;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h5000_0000;
        exp_q.push_back('{addr: 32'h0000_0300, write: 1'b0});
        settle();
        check("t6_m0_first", S_HADDR, 32'h0000_0300);
        nxt();
        idle_masters();
        HRESETn = 1'b0;
        settle();
        check("t6_rst_s_htrans", 32'(S_HTRANS), 32'd0);
        check("t6_rst_m1_hready", 32'(M1_HREADY), 32'd1);
        nxt();
        HRESETn = 1'b1;
        settle();
        check("t6_s_htrans", 32'(S_HTRANS), 32'd0);
        check("t6_m0_hready", 32'(M0_HREADY), 32'd1);
        check("t6_m1_hready", 32'(M1_HREADY), 32'd1);
        nxt();
        for (int c = 0; c < 3; c++) begin
            settle();
            nxt();
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
